// File: rtl/vote_logger_if.sv
// Button/mode inputs and tally/pulse outputs of the vote logger, grouped for port connection.
interface vote_logger_if #(
  parameter int CNT_W = 8
);
  logic             mode;
  logic             cand1_button;
  logic             cand2_button;
  logic             cand3_button;
  logic             cand4_button;
  logic [CNT_W-1:0] cand1_vote;
  logic [CNT_W-1:0] cand2_vote;
  logic [CNT_W-1:0] cand3_vote;
  logic [CNT_W-1:0] cand4_vote;
  logic             valid_vote_casted;
  logic             invalid_vote;
  logic             busy;

  modport master (
    output mode, cand1_button, cand2_button, cand3_button, cand4_button,
    input  cand1_vote, cand2_vote, cand3_vote, cand4_vote,
    input  valid_vote_casted, invalid_vote, busy
  );

  modport slave (
    input  mode, cand1_button, cand2_button, cand3_button, cand4_button,
    output cand1_vote, cand2_vote, cand3_vote, cand4_vote,
    output valid_vote_casted, invalid_vote, busy
  );
endinterface

// File: rtl/vote_logger.sv
// Synchronise/debounce four candidate buttons and tally one vote per press (no backpressure).
// Latency: raw high sampled at edge E0 -> tally and pulse update on edge E0+2+DEBOUNCE_CYCLES.
module vote_logger #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic          clk,
  input  logic          rst,
  vote_logger_if.slave  bus
);

  localparam int            DW      = 24;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] IDLE         = 1'b0;
  localparam logic [0:0] WAIT_RELEASE = 1'b1;

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       db;
  logic [DW-1:0]    db_cnt [4];
  logic [0:0]       state;
  logic [CNT_W-1:0] tally [4];
  logic             vld;
  logic             inv;
  logic [3:0]       sat;
  logic             one_hot;

  assign raw = {bus.cand4_button, bus.cand3_button, bus.cand2_button, bus.cand1_button};

  // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= ~db[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    sat = '0;
    for (int i = 0; i < 4; i++) sat[i] = &tally[i];
  end

  assign one_hot = (db != 4'd0) && ((db & (db - 4'd1)) == 4'd0);

  // Any press seen in IDLE moves to WAIT_RELEASE, so a held button counts at most once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      vld   <= 1'b0;
      inv   <= 1'b0;
      for (int i = 0; i < 4; i++) tally[i] <= '0;
    end else begin
      vld <= 1'b0;
      inv <= 1'b0;
      case (state)
        IDLE: begin
          if (db != 4'd0) begin
            state <= WAIT_RELEASE;
            if (!bus.mode) begin
              if (one_hot && ((db & sat) == 4'd0)) begin
                for (int i = 0; i < 4; i++)
                  if (db[i]) tally[i] <= tally[i] + CNT_W'(1);
                vld <= 1'b1;
              end else begin
                inv <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (db == 4'd0) state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cand1_vote        = tally[0];
  assign bus.cand2_vote        = tally[1];
  assign bus.cand3_vote        = tally[2];
  assign bus.cand4_vote        = tally[3];
  assign bus.valid_vote_casted = vld;
  assign bus.invalid_vote      = inv;
  assign bus.busy              = (state != IDLE);

endmodule

// File: tb/tb_vote_logger.sv
// Directed test of vote_logger with DEBOUNCE_CYCLES=4, CNT_W=8.
module tb_vote_logger;

  logic clk;
  logic rst;
  int   nvec;
  int   nfail;
  int   nval;
  int   ninv;
  int   nboth;
  int   v0;
  int   i0;

  vote_logger_if #(.CNT_W(8)) bus ();

  vote_logger #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.valid_vote_casted) nval++;
      if (bus.invalid_vote) ninv++;
      if (bus.valid_vote_casted && bus.invalid_vote) nboth++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      1: bus.cand1_button = v;
      2: bus.cand2_button = v;
      3: bus.cand3_button = v;
      default: bus.cand4_button = v;
    endcase
  endtask

  task automatic press_release(input int idx);
    set_btn(idx, 1'b1);
    step(8);
    set_btn(idx, 1'b0);
    step(8);
  endtask

  initial begin
    nvec = 0; nfail = 0; nval = 0; ninv = 0; nboth = 0;
    rst = 1'b0;
    bus.mode = 1'b0;
    bus.cand1_button = 1'b0;
    bus.cand2_button = 1'b0;
    bus.cand3_button = 1'b0;
    bus.cand4_button = 1'b0;
    step(3);
    chk("rst_c1", 32'(bus.cand1_vote), 0);
    chk("rst_c2", 32'(bus.cand2_vote), 0);
    chk("rst_c3", 32'(bus.cand3_vote), 0);
    chk("rst_c4", 32'(bus.cand4_vote), 0);
    chk("rst_pulses", {30'd0, bus.valid_vote_casted, bus.invalid_vote}, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b1;
    step(2);

    // Single press on cand2: counted exactly at edge E6.
    bus.cand2_button = 1'b1;
    step(6);
    chk("single_pre_tally", 32'(bus.cand2_vote), 0);
    chk("single_pre_vld", 32'(bus.valid_vote_casted), 0);
    step(1);
    chk("single_tally", 32'(bus.cand2_vote), 1);
    chk("single_vld", 32'(bus.valid_vote_casted), 1);
    chk("single_busy", 32'(bus.busy), 1);
    step(1);
    chk("single_vld_end", 32'(bus.valid_vote_casted), 0);
    step(18);
    chk("single_one_pulse", 32'(nval), 1);
    chk("single_others", 32'(bus.cand1_vote) + 32'(bus.cand3_vote) + 32'(bus.cand4_vote), 0);
    bus.cand2_button = 1'b0;
    step(8);
    chk("single_idle", 32'(bus.busy), 0);

    // Three-cycle glitch on cand1 must be filtered out.
    bus.cand1_button = 1'b1;
    step(3);
    bus.cand1_button = 1'b0;
    step(10);
    chk("glitch_tally", 32'(bus.cand1_vote), 0);
    chk("glitch_pulses", 32'(nval + ninv), 1);
    chk("glitch_busy", 32'(bus.busy), 0);

    // Simultaneous cand1+cand3 press is rejected.
    bus.cand1_button = 1'b1;
    bus.cand3_button = 1'b1;
    step(6);
    chk("simul_pre_inv", 32'(bus.invalid_vote), 0);
    step(1);
    chk("simul_inv", 32'(bus.invalid_vote), 1);
    chk("simul_vld", 32'(bus.valid_vote_casted), 0);
    step(5);
    chk("simul_ninv", 32'(ninv), 1);
    chk("simul_tallies", 32'(bus.cand1_vote) + 32'(bus.cand3_vote), 0);
    bus.cand1_button = 1'b0;
    bus.cand3_button = 1'b0;
    step(8);
    press_release(3);
    chk("simul_c3_after", 32'(bus.cand3_vote), 1);

    // Saturation on cand4.
    v0 = nval;
    i0 = ninv;
    for (int k = 0; k < 255; k++) press_release(4);
    chk("sat_255", 32'(bus.cand4_vote), 255);
    chk("sat_nval", 32'(nval - v0), 255);
    press_release(4);
    chk("sat_256_tally", 32'(bus.cand4_vote), 255);
    chk("sat_256_inv", 32'(ninv - i0), 1);
    chk("sat_256_nval", 32'(nval - v0), 255);

    // Mode interlock: press in result mode, switch back while held.
    v0 = nval;
    bus.mode = 1'b1;
    bus.cand1_button = 1'b1;
    step(10);
    chk("mode_res_tally", 32'(bus.cand1_vote), 0);
    chk("mode_res_busy", 32'(bus.busy), 1);
    bus.mode = 1'b0;
    step(10);
    chk("mode_held_tally", 32'(bus.cand1_vote), 0);
    chk("mode_held_nval", 32'(nval - v0), 0);
    bus.cand1_button = 1'b0;
    step(8);
    press_release(1);
    chk("mode_repress", 32'(bus.cand1_vote), 1);

    // Async reset mid-hold, then cand2 still held after release.
    bus.cand2_button = 1'b1;
    step(10);
    chk("arst_pre_c2", 32'(bus.cand2_vote), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tallies", 32'(bus.cand1_vote) + 32'(bus.cand2_vote) +
                        32'(bus.cand3_vote) + 32'(bus.cand4_vote), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_pulses", {30'd0, bus.valid_vote_casted, bus.invalid_vote}, 0);
    step(2);
    rst = 1'b1;
    step(6);
    chk("arst_pre_count", 32'(bus.cand2_vote), 0);
    step(1);
    chk("arst_count", 32'(bus.cand2_vote), 1);
    chk("arst_vld", 32'(bus.valid_vote_casted), 1);
    step(10);
    chk("arst_once", 32'(bus.cand2_vote), 1);
    bus.cand2_button = 1'b0;
    step(8);
    chk("never_both", 32'(nboth), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/vote_logger.md
Name: vote_logger

Overview:
Upstream stage of the mode-control/LED block. It takes the four raw candidate push-buttons and produces the per-candidate 8-bit vote tallies plus the single-cycle valid_vote_casted pulse that the mode-control block consumes. It synchronises, debounces and edge-qualifies the buttons, and enforces one vote per press. It rejects simultaneous presses and does not count votes while in result mode.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed before a debounced level changes. Use 4 in simulation; 1_000_000 gives 10 ms at 100 MHz. Legal range 1..2^24-1.
CNT_W, 8, width of each vote tally.

Ports:
clk  input  1  system clock, all flops rising-edge
rst  input  1  asynchronous, active-low reset
mode  input  1  0 = voting, 1 = result display (same signal the mode-control block uses)
cand1_button  input  1  raw, asynchronous push-button, active-high
cand2_button  input  1  as above
cand3_button  input  1  as above
cand4_button  input  1  as above
cand1_vote  output  CNT_W  tally for candidate 1
cand2_vote  output  CNT_W  tally for candidate 2
cand3_vote  output  CNT_W  tally for candidate 3
cand4_vote  output  CNT_W  tally for candidate 4
valid_vote_casted  output  1  one-cycle pulse when a vote is counted
invalid_vote  output  1  one-cycle pulse when a press is rejected
busy  output  1  high while the FSM is in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - All tallies 0; valid_vote_casted=0; invalid_vote=0; busy=0.
  - Synchroniser and debounce flops cleared; debounce counters cleared; FSM=IDLE.
  - Takes effect immediately and overrides any vote in flight. No partial increment survives.
- Synchroniser: two flops per button. s[i] is raw[i] delayed by 2 edges.
- Debounce, per button, independent of the others:
  - Counter counts edges on which s[i] != db[i]. It clears to 0 on any edge where s[i] == db[i].
  - When the counter reaches DEBOUNCE_CYCLES, db[i] toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes db[i].
- FSM states: IDLE, WAIT_RELEASE. Let db = the four debounced bits.
  - IDLE, mode=1: if db!=0, go to WAIT_RELEASE with no pulse; else stay.
  - IDLE, mode=0, exactly one db bit set, that tally < 2^CNT_W-1:
    - Tally+1 and valid_vote_casted=1 on the same edge.
    - Go to WAIT_RELEASE.
  - IDLE, mode=0, exactly one db bit set, that tally == 2^CNT_W-1 (saturated):
    - Tally unchanged, invalid_vote=1, go to WAIT_RELEASE.
  - IDLE, mode=0, two or more db bits set: no tally changes, invalid_vote=1, go to WAIT_RELEASE.
  - WAIT_RELEASE: stay while db!=0; go to IDLE on the first edge where db==0. No pulses in this state.
- Latency: raw level sampled high at edge E0 and held → db high after edge E0+1+DEBOUNCE_CYCLES → tally and pulse update after edge E0+2+DEBOUNCE_CYCLES.
- Pulses last exactly one cycle. At most one of valid_vote_casted / invalid_vote is high in any cycle.
- Holding a button produces exactly one vote. A new vote requires every button released, then a new press.
- Mode change:
  - mode switching 0→1 while in WAIT_RELEASE has no effect.
  - Buttons held across a 1→0 switch are never counted; the FSM passes through WAIT_RELEASE first.
- Tallies change only on a valid vote and are read combinationally from registers, so they are stable in result mode.
- busy = (state != IDLE).

Test Plan:
- Single press, DEBOUNCE_CYCLES=4: raise cand2_button before E0, hold 20 cycles → cand2_vote 0→1 and valid_vote_casted high for 1 cycle after edge E6; other tallies stay 0; no further pulses while held.
- Glitch rejection: cand1_button high for 3 cycles then low → no db change, no pulses, cand1_vote=0.
- Simultaneous press: cand1 and cand3 rise on the same cycle → invalid_vote pulses once, all tallies stay 0; after release, a cand3-only press gives cand3_vote=1.
- Saturation: 256 separate press/release cycles on cand4 → cand4_vote=255 after press 255 with 255 valid pulses; press 256 → cand4_vote stays 255 and invalid_vote pulses.
- Mode interlock: mode=1, press cand1 (result viewing) → no count; switch mode=0 while still held → no count; release and press again → cand1_vote=1.
- Async reset mid-operation: after 3 votes, pull rst low between clock edges while cand2 is held → all outputs 0 immediately; release rst with cand2 still held → cand2 is counted once, DEBOUNCE_CYCLES+3 edges later.
